// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: the four stage instruction registers coming in
// from the datapath and the stall / busy / forwarding selects going back out.
// The datapath side uses the master modport, the hazard controller the slave.
interface hazard_ctrl_if;
   logic [31:0] InstrD;
   logic [31:0] InstrE;
   logic [31:0] InstrM;
   logic [31:0] InstrW;
   logic        Stall;
   logic        MduBusy;
   logic [1:0]  FwdRsD;
   logic [1:0]  FwdRtD;
   logic [1:0]  FwdRsE;
   logic [1:0]  FwdRtE;
   logic        FwdRtM;
   logic [31:0] StallCnt;

   modport master (
      output InstrD, InstrE, InstrM, InstrW,
      input  Stall, MduBusy, FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM, StallCnt
   );

   modport slave (
      input  InstrD, InstrE, InstrM, InstrW,
      output Stall, MduBusy, FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM, StallCnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline (F/D/E/M/W).
// Decides D-stage stalls by comparing operand Tuse against producer Tnew,
// generates every forwarding select, and tracks the multi-cycle MDU in E.
// Optional: define HAZARD_PERF_EN to build a 32-bit stall-cycle counter
// on StallCnt; without it StallCnt is a constant zero.
module hazard_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10,
   parameter int unsigned CNT_W       = 4
) (
   input logic          clk,
   input logic          reset,
   hazard_ctrl_if.slave hz
);

   // Everything the hazard logic needs to know about one instruction.
   typedef struct packed {
      logic       rs_used;
      logic       rt_used;
      logic [1:0] tuse_rs;
      logic [1:0] tuse_rt;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] dest;
      logic [1:0] tnew_e;
      logic       is_lw;
      logic       is_jal;
      logic       is_mdu_start;
      logic       is_div;
      logic       is_mdu_any;
   } dec_t;

   // Unsupported opcodes fall through as nops: no reads, no writes.
   function automatic dec_t decode(input logic [31:0] instr);
      dec_t       d;
      logic [5:0] op;
      logic [5:0] funct;
      op           = instr[31:26];
      funct        = instr[5:0];
      d            = '0;
      d.rs         = instr[25:21];
      d.rt         = instr[20:16];
      case (op)
         6'h00: begin
            case (funct)
               6'h21, 6'h23: begin
                  d.rs_used = 1'b1;
                  d.rt_used = 1'b1;
                  d.tuse_rs = 2'd1;
                  d.tuse_rt = 2'd1;
                  d.dest    = instr[15:11];
                  d.tnew_e  = 2'd1;
               end
               6'h08: begin
                  d.rs_used = 1'b1;
                  d.tuse_rs = 2'd0;
               end
               6'h18, 6'h19, 6'h1A, 6'h1B: begin
                  d.rs_used      = 1'b1;
                  d.rt_used      = 1'b1;
                  d.tuse_rs      = 2'd1;
                  d.tuse_rt      = 2'd1;
                  d.is_mdu_start = 1'b1;
                  d.is_div       = funct[1];
                  d.is_mdu_any   = 1'b1;
               end
               6'h10, 6'h12: begin
                  d.dest       = instr[15:11];
                  d.tnew_e     = 2'd1;
                  d.is_mdu_any = 1'b1;
               end
               6'h11, 6'h13: begin
                  d.rs_used    = 1'b1;
                  d.tuse_rs    = 2'd1;
                  d.is_mdu_any = 1'b1;
               end
               default: d.is_mdu_any = 1'b0;
            endcase
         end
         6'h0D, 6'h0F: begin
            d.rs_used = 1'b1;
            d.tuse_rs = 2'd1;
            d.dest    = instr[20:16];
            d.tnew_e  = 2'd1;
         end
         6'h23: begin
            d.rs_used = 1'b1;
            d.tuse_rs = 2'd1;
            d.dest    = instr[20:16];
            d.tnew_e  = 2'd2;
            d.is_lw   = 1'b1;
         end
         6'h2B: begin
            d.rs_used = 1'b1;
            d.rt_used = 1'b1;
            d.tuse_rs = 2'd1;
            d.tuse_rt = 2'd2;
         end
         6'h04: begin
            d.rs_used = 1'b1;
            d.rt_used = 1'b1;
            d.tuse_rs = 2'd0;
            d.tuse_rt = 2'd0;
         end
         6'h03: begin
            d.dest   = 5'd31;
            d.tnew_e = 2'd0;
            d.is_jal = 1'b1;
         end
         default: d.rs_used = 1'b0;
      endcase
      // Writes to $0 are discarded, so they never act as a producer.
      if (d.dest == 5'd0) begin
         d.tnew_e = 2'd0;
      end
      return d;
   endfunction

   dec_t dec_d;
   dec_t dec_e;
   dec_t dec_m;
   dec_t dec_w;

   logic [1:0]       tnew_m;
   logic             stall_data;
   logic             stall_mdu;
   logic             stall;
   logic             mdu_busy;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;
   logic             unused_dec_bits;

   assign dec_d = decode(hz.InstrD);
   assign dec_e = decode(hz.InstrE);
   assign dec_m = decode(hz.InstrM);
   assign dec_w = decode(hz.InstrW);

   // Not every decoded field is needed in every stage.
   assign unused_dec_bits = ^{dec_d, dec_e, dec_m, dec_w};

   // A load still in M has one cycle to go; everything else in M is ready.
   assign tnew_m = {1'b0, dec_m.is_lw};

   // D-stage stall: an operand is needed before its producer in E or M has it.
   always_comb begin
      stall_data = 1'b0;
      if (dec_d.rs_used && dec_d.rs != 5'd0) begin
         if (dec_e.dest == dec_d.rs && dec_d.tuse_rs < dec_e.tnew_e) stall_data = 1'b1;
         if (dec_m.dest == dec_d.rs && dec_d.tuse_rs < tnew_m)       stall_data = 1'b1;
      end
      if (dec_d.rt_used && dec_d.rt != 5'd0) begin
         if (dec_e.dest == dec_d.rt && dec_d.tuse_rt < dec_e.tnew_e) stall_data = 1'b1;
         if (dec_m.dest == dec_d.rt && dec_d.tuse_rt < tnew_m)       stall_data = 1'b1;
      end
   end

   // The MDU counts as busy already in the cycle its start instruction sits in E.
   assign mdu_busy  = (cnt_q != '0) || dec_e.is_mdu_start;
   assign stall_mdu = dec_d.is_mdu_any && mdu_busy;
   assign stall     = stall_data || stall_mdu;

   assign hz.Stall   = stall;
   assign hz.MduBusy = mdu_busy;

   // D-stage forwarding: only a jal in E has its value ready; M skips loads.
   always_comb begin
      hz.FwdRsD = 2'd0;
      hz.FwdRtD = 2'd0;
      if (dec_d.rs_used && dec_d.rs != 5'd0) begin
         if (dec_e.is_jal && dec_e.dest == dec_d.rs)         hz.FwdRsD = 2'd1;
         else if (dec_m.dest == dec_d.rs && tnew_m == 2'd0) hz.FwdRsD = 2'd2;
         else if (dec_w.dest == dec_d.rs)                    hz.FwdRsD = 2'd3;
      end
      if (dec_d.rt_used && dec_d.rt != 5'd0) begin
         if (dec_e.is_jal && dec_e.dest == dec_d.rt)         hz.FwdRtD = 2'd1;
         else if (dec_m.dest == dec_d.rt && tnew_m == 2'd0) hz.FwdRtD = 2'd2;
         else if (dec_w.dest == dec_d.rt)                    hz.FwdRtD = 2'd3;
      end
   end

   // E-stage forwarding: M (non-load) beats W.
   always_comb begin
      hz.FwdRsE = 2'd0;
      hz.FwdRtE = 2'd0;
      if (dec_e.rs_used && dec_e.rs != 5'd0) begin
         if (dec_m.dest == dec_e.rs && tnew_m == 2'd0) hz.FwdRsE = 2'd2;
         else if (dec_w.dest == dec_e.rs)               hz.FwdRsE = 2'd3;
      end
      if (dec_e.rt_used && dec_e.rt != 5'd0) begin
         if (dec_m.dest == dec_e.rt && tnew_m == 2'd0) hz.FwdRtE = 2'd2;
         else if (dec_w.dest == dec_e.rt)               hz.FwdRtE = 2'd3;
      end
   end

   // M-stage store data can only come from W.
   always_comb begin
      hz.FwdRtM = 1'b0;
      if (dec_m.rt_used && dec_m.rt != 5'd0 && dec_w.dest == dec_m.rt) begin
         hz.FwdRtM = 1'b1;
      end
   end

   // MDU busy counter: a start in E always (re)loads, otherwise count down.
   always_comb begin
      cnt_d = cnt_q;
      if (dec_e.is_mdu_start) begin
         cnt_d = dec_e.is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // MDU busy counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_d;
   logic [31:0] stall_cnt_q;

   // Count stalled cycles, wrapping naturally at 32 bits.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Stall-cycle counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.StallCnt = stall_cnt_q;
`else
   assign hz.StallCnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: hand-built MIPS instruction vectors
// are placed in the D/E/M/W slots and every output is compared against
// values worked out by hand. StallCnt expectations depend on HAZARD_PERF_EN.
module tb_hazard_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   num_checks = 0;
   int   num_fails  = 0;

   hazard_ctrl_if hz_if();

   hazard_ctrl #(
      .MULT_CYCLES(5),
      .DIV_CYCLES (10),
      .CNT_W      (4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .hz   (hz_if)
   );

   // 10 time-unit clock.
   always #5 clk = ~clk;

   function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
      return {6'h00, rs, rt, rd, 5'h00, funct};
   endfunction

   function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic applyStimulus(input logic [31:0] d, input logic [31:0] e,
                                input logic [31:0] m, input logic [31:0] w);
      hz_if.InstrD = d;
      hz_if.InstrE = e;
      hz_if.InstrM = m;
      hz_if.InstrW = w;
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   logic [31:0] lw1, addu2, ori1, ori5, beq55, lw5, lw6, jal_i, jr31, ori31;
   logic [31:0] sw5, sw0, addu0, addu_z, div12, mult12, mflo4, mfhi4, mthi1;
   logic [31:0] perf_exp;

   initial begin
      lw1    = i_type(6'h23, 5'd0, 5'd1, 16'h0);
      addu2  = r_type(5'd1, 5'd3, 5'd2, 6'h21);
      ori1   = i_type(6'h0D, 5'd0, 5'd1, 16'h7);
      ori5   = i_type(6'h0D, 5'd0, 5'd5, 16'h7);
      beq55  = i_type(6'h04, 5'd5, 5'd5, 16'h3);
      lw5    = i_type(6'h23, 5'd0, 5'd5, 16'h0);
      lw6    = i_type(6'h23, 5'd0, 5'd6, 16'h0);
      jal_i  = {6'h03, 26'h0000040};
      jr31   = r_type(5'd31, 5'd0, 5'd0, 6'h08);
      ori31  = i_type(6'h0D, 5'd0, 5'd31, 16'h1);
      sw5    = i_type(6'h2B, 5'd6, 5'd5, 16'h0);
      sw0    = i_type(6'h2B, 5'd6, 5'd0, 16'h0);
      addu0  = r_type(5'd1, 5'd1, 5'd0, 6'h21);
      addu_z = r_type(5'd0, 5'd0, 5'd2, 6'h21);
      div12  = r_type(5'd1, 5'd2, 5'd0, 6'h1A);
      mult12 = r_type(5'd1, 5'd2, 5'd0, 6'h18);
      mflo4  = r_type(5'd0, 5'd0, 5'd4, 6'h12);
      mfhi4  = r_type(5'd0, 5'd0, 5'd4, 6'h10);
      mthi1  = r_type(5'd1, 5'd0, 5'd0, 6'h11);

      // Reset state with an all-bubble pipeline.
      reset = 1'b1;
      applyStimulus(32'h0, 32'h0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #2;
      checkOutput("rst_busy", 32'(hz_if.MduBusy), 32'd0);
      checkOutput("rst_stall", 32'(hz_if.Stall), 32'd0);
      checkOutput("rst_stallcnt", hz_if.StallCnt, 32'd0);
      checkOutput("rst_fwd", 32'({hz_if.FwdRsD, hz_if.FwdRtD, hz_if.FwdRsE,
                                   hz_if.FwdRtE, hz_if.FwdRtM}), 32'd0);
      reset = 1'b0;

      // Load-use: lw $1 in E, addu $2,$1,$3 in D.
      nextCycle(); applyStimulus(addu2, 32'h0, 32'h0, 32'h0);
      applyStimulus(addu2, lw1, 32'h0, 32'h0);
      checkOutput("lu_stall_e", 32'(hz_if.Stall), 32'd1);
      nextCycle(); applyStimulus(addu2, 32'h0, lw1, 32'h0);
      checkOutput("lu_stall_m", 32'(hz_if.Stall), 32'd0);
      checkOutput("lu_fwdrsd_m", 32'(hz_if.FwdRsD), 32'd0);
      nextCycle(); applyStimulus(32'h0, addu2, lw1, 32'h0);
      checkOutput("lu_stall_e2", 32'(hz_if.Stall), 32'd0);
      checkOutput("lu_fwdrse_m", 32'(hz_if.FwdRsE), 32'd0);
      nextCycle(); applyStimulus(32'h0, addu2, 32'h0, lw1);
      checkOutput("lu_fwdrse_w", 32'(hz_if.FwdRsE), 32'd3);
      checkOutput("lu_fwdrte_w", 32'(hz_if.FwdRtE), 32'd0);
      nextCycle(); applyStimulus(32'h0, addu2, ori1, lw1);
      checkOutput("e_prio_m", 32'(hz_if.FwdRsE), 32'd2);

      // Branch operands.
      nextCycle(); applyStimulus(beq55, 32'h0, ori5, 32'h0);
      checkOutput("beq_stall_m", 32'(hz_if.Stall), 32'd0);
      checkOutput("beq_fwdrsd", 32'(hz_if.FwdRsD), 32'd2);
      checkOutput("beq_fwdrtd", 32'(hz_if.FwdRtD), 32'd2);
      nextCycle(); applyStimulus(beq55, ori5, 32'h0, 32'h0);
      checkOutput("beq_stall_e", 32'(hz_if.Stall), 32'd1);
      nextCycle(); applyStimulus(beq55, 32'h0, lw5, ori5);
      checkOutput("beq_stall_lwm", 32'(hz_if.Stall), 32'd1);
      checkOutput("beq_fwd_skip_lw", 32'(hz_if.FwdRsD), 32'd3);

      // jal / jr $31.
      nextCycle(); applyStimulus(jr31, jal_i, 32'h0, 32'h0);
      checkOutput("jr_stall", 32'(hz_if.Stall), 32'd0);
      checkOutput("jr_fwd_e", 32'(hz_if.FwdRsD), 32'd1);
      nextCycle(); applyStimulus(jr31, 32'h0, jal_i, ori31);
      checkOutput("jr_fwd_m", 32'(hz_if.FwdRsD), 32'd2);
      nextCycle(); applyStimulus(jr31, ori31, 32'h0, 32'h0);
      checkOutput("jr_stall_ori", 32'(hz_if.Stall), 32'd1);

      // Store data has a late Tuse; store base does not.
      nextCycle(); applyStimulus(sw5, lw5, 32'h0, 32'h0);
      checkOutput("sw_rt_nostall", 32'(hz_if.Stall), 32'd0);
      nextCycle(); applyStimulus(sw5, lw6, 32'h0, 32'h0);
      checkOutput("sw_rs_stall", 32'(hz_if.Stall), 32'd1);
      nextCycle(); applyStimulus(32'h0, 32'h0, sw5, lw5);
      checkOutput("sw_fwdrtm", 32'(hz_if.FwdRtM), 32'd1);
      nextCycle(); applyStimulus(32'h0, 32'h0, sw0, addu0);
      checkOutput("sw0_fwdrtm", 32'(hz_if.FwdRtM), 32'd0);

      // $0 writers are never producers.
      nextCycle(); applyStimulus(addu_z, addu0, 32'h0, 32'h0);
      checkOutput("z_stall", 32'(hz_if.Stall), 32'd0);
      checkOutput("z_fwdrsd_e", 32'(hz_if.FwdRsD), 32'd0);
      nextCycle(); applyStimulus(addu_z, 32'h0, addu0, addu0);
      checkOutput("z_fwdrsd", 32'(hz_if.FwdRsD), 32'd0);
      checkOutput("z_fwdrtd", 32'(hz_if.FwdRtD), 32'd0);
      nextCycle(); applyStimulus(32'h0, addu_z, addu0, addu0);
      checkOutput("z_fwdrse", 32'(hz_if.FwdRsE), 32'd0);

      // Divide: busy from the E cycle for 10 more cycles.
      nextCycle(); applyStimulus(32'h0, div12, 32'h0, 32'h0);
      checkOutput("div_busy_t", 32'(hz_if.MduBusy), 32'd1);
      checkOutput("div_stall_t", 32'(hz_if.Stall), 32'd0);
      for (int i = 1; i <= 10; i++) begin
         nextCycle(); applyStimulus(mflo4, 32'h0, 32'h0, 32'h0);
         checkOutput("div_busy", 32'(hz_if.MduBusy), 32'd1);
         checkOutput("div_stall", 32'(hz_if.Stall), 32'd1);
      end
      nextCycle(); applyStimulus(mflo4, 32'h0, 32'h0, 32'h0);
      checkOutput("div_done_busy", 32'(hz_if.MduBusy), 32'd0);
      checkOutput("div_done_stall", 32'(hz_if.Stall), 32'd0);

      // Reload: mult started while divide count is 9 -> 5 more busy cycles.
      nextCycle(); applyStimulus(32'h0, div12, 32'h0, 32'h0);
      nextCycle(); applyStimulus(32'h0, 32'h0, 32'h0, 32'h0);
      nextCycle(); applyStimulus(32'h0, mult12, 32'h0, 32'h0);
      checkOutput("reload_busy", 32'(hz_if.MduBusy), 32'd1);
      for (int i = 1; i <= 5; i++) begin
         nextCycle(); applyStimulus(mthi1, 32'h0, 32'h0, 32'h0);
         checkOutput("reload_cnt_busy", 32'(hz_if.MduBusy), 32'd1);
         checkOutput("reload_mthi_stall", 32'(hz_if.Stall), 32'd1);
      end
      nextCycle(); applyStimulus(mthi1, 32'h0, 32'h0, 32'h0);
      checkOutput("reload_done", 32'(hz_if.MduBusy), 32'd0);
      checkOutput("reload_done_stall", 32'(hz_if.Stall), 32'd0);

      // Reset in the middle of a multiply.
      nextCycle(); applyStimulus(32'h0, mult12, 32'h0, 32'h0);
      nextCycle(); applyStimulus(32'h0, 32'h0, 32'h0, 32'h0);
      checkOutput("mrst_busy_t1", 32'(hz_if.MduBusy), 32'd1);
      nextCycle(); reset = 1'b1; applyStimulus(32'h0, 32'h0, 32'h0, 32'h0);
      checkOutput("mrst_busy_t2", 32'(hz_if.MduBusy), 32'd1);
      nextCycle(); reset = 1'b0; applyStimulus(mfhi4, 32'h0, 32'h0, 32'h0);
      checkOutput("mrst_busy_t3", 32'(hz_if.MduBusy), 32'd0);
      checkOutput("mrst_stall_t3", 32'(hz_if.Stall), 32'd0);
      nextCycle(); reset = 1'b1; applyStimulus(32'h0, mult12, 32'h0, 32'h0);
      checkOutput("rst_e_mdu_busy", 32'(hz_if.MduBusy), 32'd1);
      nextCycle(); reset = 1'b0; applyStimulus(mfhi4, 32'h0, 32'h0, 32'h0);
      checkOutput("rst_beats_load", 32'(hz_if.MduBusy), 32'd0);

      // Perf counter: three separate one-cycle load-use stalls after reset.
      nextCycle(); reset = 1'b1; applyStimulus(32'h0, 32'h0, 32'h0, 32'h0);
      nextCycle(); reset = 1'b0;
      checkOutput("perf_clear", hz_if.StallCnt, 32'd0);
      for (int i = 1; i <= 3; i++) begin
         nextCycle(); applyStimulus(addu2, lw1, 32'h0, 32'h0);
         checkOutput("perf_stall", 32'(hz_if.Stall), 32'd1);
         nextCycle(); applyStimulus(32'h0, 32'h0, 32'h0, 32'h0);
         checkOutput("perf_nostall", 32'(hz_if.Stall), 32'd0);
`ifdef HAZARD_PERF_EN
         perf_exp = 32'(i);
`else
         perf_exp = 32'd0;
`endif
         checkOutput("perf_cnt_step", hz_if.StallCnt, perf_exp);
      end
      nextCycle();
`ifdef HAZARD_PERF_EN
      perf_exp = 32'd3;
`else
      perf_exp = 32'd0;
`endif
      checkOutput("perf_cnt_final", hz_if.StallCnt, perf_exp);

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard controller for the 5-stage MIPS pipeline (F/D/E/M/W), replacing the per-class equality stall logic with Tuse/Tnew comparison.
- Generates the D-stage stall and all forwarding-mux selects.
- Tracks a multi-cycle multiply/divide unit (MDU) in E with an internal busy counter, and stalls HI/LO-touching instructions in D while the MDU is busy.
- Sits beside the datapath and is driven only by the four stage instruction registers.

Parameters:
MULT_CYCLES, 5, E-stage busy cycles for mult/multu (1..15)
DIV_CYCLES, 10, E-stage busy cycles for div/divu (1..15)
CNT_W, 4, width of MDU busy counter; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high; clears MDU counter (and perf counters)
InstrD  in  32  instruction in D
InstrE  in  32  instruction in E (bubble = 32'h0)
InstrM  in  32  instruction in M
InstrW  in  32  instruction in W
Stall  out  1  freeze PC and F/D register, flush D/E register
MduBusy  out  1  MDU currently computing
FwdRsD  out  2  D-stage rs mux: 0 RF, 1 E(PC+8 of jal), 2 M, 3 W
FwdRtD  out  2  D-stage rt mux, same encoding
FwdRsE  out  2  E-stage rs mux: 0 pipe reg, 2 M, 3 W (1 unused)
FwdRtE  out  2  E-stage rt mux, same as FwdRsE
FwdRtM  out  1  M-stage store-data mux: 0 pipe reg, 1 W
StallCnt  out  32  perf counter (see Optional Feature)

Behaviour:
Supported set: addu subu ori lui lw sw beq j jal jr mult multu div divu mfhi mflo mthi mtlo; anything else is a nop (no read, no write).
Destination register per stage:
- cal_r/mf -> rd; ori/lui/lw -> rt; jal -> 31; others none.
- Writes to $0 are never hazards or forward sources.
Tuse(D), per operand:
- beq rs/rt = 0; jr rs = 0.
- addu/subu rs/rt = 1; ori/lui/lw/sw rs = 1; mult/div rs/rt = 1; mthi/mtlo rs = 1.
- sw rt = 2.
Tnew, per stage:
- E: cal/mf = 1, lw = 2, jal = 0.
- M: lw = 1, others 0.
- W: 0.
Data stall: (rs used and addr match with E/M dest and Tuse_rs < Tnew) OR same condition for rt. Purely combinational.
MDU counter (cnt, CNT_W bits, reset 0), updated each rising edge:
- reset -> 0.
- InstrE is mult/multu -> MULT_CYCLES.
- InstrE is div/divu -> DIV_CYCLES.
- cnt != 0 -> cnt-1.
- Otherwise hold.
- An E-stage start while cnt != 0 reloads. This cannot occur in legal flow; the bench checks that reload wins.
MduBusy = (cnt != 0) OR InstrE is mult/multu/div/divu. Combinational, so the start cycle is already busy.
MDU stall: D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo AND MduBusy.
Stall = data stall OR MDU stall.
Forward priority, nearest stage first, only from a stage whose Tnew == 0 for that value, non-zero matching dest:
- D operands: E(jal only) > M > W > RF.
- E operands: M > W.
- M rt: W.
- Select is 0 when no match.
- Selects are meaningful even while Stall is high; the datapath ignores them.
Reset outputs: cnt = 0, so MduBusy and Stall follow instruction inputs only; StallCnt = 0.
Reset asserted mid-divide: counter 0 on the next edge, busy drops unless InstrE is still an MDU op.

Optional Feature:
HAZARD_PERF_EN
- Defined: 32-bit StallCnt increments every cycle Stall = 1, wraps 32'hFFFFFFFF -> 0, and clears on reset.
- Undefined: StallCnt is tied to 32'h0 and no counter register exists.

Test Plan:
1. lw $1,0($0) in E, addu $2,$1,$3 in D -> Stall = 1 one cycle. Next cycle lw in M, addu in E: Stall = 0, FwdRsE = 0; following cycle FwdRsE = 3 (W).
2. ori $5,$0,7 in M, beq $5,$5 in D -> Stall = 0, FwdRsD = FwdRtD = 2. Same ori in E -> Stall = 1.
3. jal in E, jr $31 in D -> Stall = 0, FwdRsD = 1.
4. div in E at cycle t, mflo in D from t+1 -> MduBusy = 1 from t through t+10; Stall = 1 cycles t+1..t+10, Stall = 0 at t+11.
5. mult started, then reset pulsed at t+2 -> cnt = 0 at t+3; MduBusy = 0, mfhi in D not stalled.
6. With HAZARD_PERF_EN, three separate 1-cycle load-use stalls -> StallCnt = 3. Without the macro -> StallCnt = 0; addu $0 writer in E never stalls or forwards.
